// File: rtl/video_frame_checker.sv
// video_frame_checker: raster sync timing checker with per-frame pixel count and RGB signature
module video_frame_checker #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_visible,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic        o_locked,
  output logic        o_frame_valid,
  output logic [10:0] o_line_len,
  output logic [9:0]  o_frame_lines,
  output logic [18:0] o_pix_count,
  output logic [23:0] o_signature,
  output logic [7:0]  o_err_count
);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOCKED} state_t;
  state_t      state_q, state_d;
  logic        hs, vs, hs_q, vs_q, hs_e, vs_e;
  logic        sync_loss, line_bad, line_err_now, frame_bad, frame_end, err_inc;
  logic        h_valid_q, h_valid_d, line_err_q, line_err_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, lines_now;
  logic [18:0] pix_q, pix_now;
  logic [23:0] sig_q, sig_now;
  assign hs   = i_hsync ^ ~SYNC_POL;
  assign vs   = i_vsync ^ ~SYNC_POL;
  assign hs_e = hs & ~hs_q;
  assign vs_e = vs & ~vs_q;
  always_comb begin
    sync_loss    = (h_cnt_q == 11'h7FF);
    h_cnt_d      = hs_e ? 11'd1 : sync_loss ? h_cnt_q : h_cnt_q + 11'd1;
    line_bad     = hs_e & h_valid_q & (h_cnt_q != 11'(H_TOTAL));
    line_err_now = line_err_q | line_bad;
    // an hsync edge on the vsync cycle still counts toward the ending frame
    lines_now    = v_cnt_q + 10'(hs_e && v_cnt_q != 10'h3FF);
    frame_bad    = line_err_now | (lines_now != 10'(V_TOTAL));
    pix_now      = pix_q + 19'(i_visible && pix_q != 19'h7FFFF);
    sig_now      = i_visible ? {sig_q[22:0], sig_q[23]} ^ {i_r, i_g, i_b} : sig_q;
    frame_end    = vs_e & (state_q != S_IDLE) & ~sync_loss;
    state_d      = sync_loss ? S_IDLE :
                   !vs_e ? state_q :
                   (state_q == S_IDLE || frame_bad) ? S_CHECK : S_LOCKED;
    err_inc      = (sync_loss & (state_q == S_LOCKED)) | (frame_end & frame_bad);
    h_valid_d    = (state_d == S_IDLE) ? 1'b0 : h_valid_q | (hs_e & (state_q != S_IDLE));
    line_err_d   = (vs_e || state_d == S_IDLE) ? 1'b0 : line_err_now;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_valid_q     <= 1'b0;
      line_err_q    <= 1'b0;
      pix_q         <= '0;
      sig_q         <= '0;
      o_locked      <= 1'b0;
      o_frame_valid <= 1'b0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
      o_pix_count   <= '0;
      o_signature   <= '0;
      o_err_count   <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs;
      vs_q          <= vs;
      h_cnt_q       <= h_cnt_d;
      h_valid_q     <= h_valid_d;
      line_err_q    <= line_err_d;
      v_cnt_q       <= vs_e ? '0 : lines_now;
      pix_q         <= vs_e ? '0 : pix_now;
      sig_q         <= vs_e ? '0 : sig_now;
      o_locked      <= (state_d == S_LOCKED);
      o_frame_valid <= frame_end;
      if (hs_e) o_line_len <= h_cnt_q;
      if (frame_end) begin
        o_frame_lines <= lines_now;
        o_pix_count   <= pix_now;
        o_signature   <= sig_now;
      end
      if (err_inc && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_video_frame_checker.sv
// tb_video_frame_checker: directed checks of sync timing, pixel signature, errors and lock
module tb_video_frame_checker;
  localparam int H = 16, V = 8, VIS_W = 12, VIS_H = 6;
  logic clk = 1'b0, rst_n = 1'b0, hs = 1'b0, vs = 1'b0, vis = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic hs_n, vs_n;
  logic        locked_a, fv_a, locked_b, fv_b;
  logic [10:0] line_len_a, line_len_b;
  logic [9:0]  lines_a, lines_b;
  logic [18:0] pix_a, pix_b;
  logic [23:0] sig_a, sig_b;
  logic [7:0]  err_a, err_b;
  int n_tests = 0, n_fail = 0, fv_cnt = 0;
  assign hs_n = ~hs;
  assign vs_n = ~vs;
  always #5 clk = ~clk;
  video_frame_checker #(.H_TOTAL(H), .V_TOTAL(V), .SYNC_POL(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_visible(vis),
    .i_r(r), .i_g(g), .i_b(b), .o_locked(locked_a), .o_frame_valid(fv_a),
    .o_line_len(line_len_a), .o_frame_lines(lines_a), .o_pix_count(pix_a),
    .o_signature(sig_a), .o_err_count(err_a));
  video_frame_checker #(.H_TOTAL(H), .V_TOTAL(V), .SYNC_POL(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs_n), .i_vsync(vs_n), .i_visible(vis),
    .i_r(r), .i_g(g), .i_b(b), .o_locked(locked_b), .o_frame_valid(fv_b),
    .o_line_len(line_len_b), .o_frame_lines(lines_b), .o_pix_count(pix_b),
    .o_signature(sig_b), .o_err_count(err_b));
  always @(negedge clk) if (fv_a) fv_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic h, input logic v, input logic vi, input logic [23:0] rgb);
    hs = h;
    vs = v;
    vis = vi;
    {r, g, b} = rgb;
    @(negedge clk);
  endtask
  task automatic run_frame(input int nlines, input int long_line, input int voff,
                           input bit vi, input logic [23:0] rgb);
    for (int l = 0; l < nlines; l++)
      for (int c = 0; c < ((l == long_line) ? H + 1 : H); c++)
        step(c == 0, l == 0 && c >= voff && c < voff + 3,
             vi && l >= 1 && l <= VIS_H && c >= 2 && c < 2 + VIS_W, rgb);
  endtask
  function automatic logic [23:0] sig_model(input logic [23:0] px, input int n);
    logic [23:0] s = '0;
    for (int i = 0; i < n; i++) s = {s[22:0], s[23]} ^ px;
    return s;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_locked", locked_a, 0);
    chk("rst_fv", fv_a, 0);
    chk("rst_line_len", line_len_a, 0);
    chk("rst_lines", lines_a, 0);
    chk("rst_pix", pix_a, 0);
    chk("rst_sig", sig_a, 0);
    chk("rst_err", err_a, 0);
    rst_n = 1'b1;
    run_frame(V, -1, 0, 0, 0);
    chk("t1_locked_f0", locked_a, 0);
    chk("t1_fv_f0", fv_cnt, 0);
    run_frame(V, -1, 0, 0, 0);
    chk("t1_locked_f1", locked_a, 1);
    chk("t1_lines", lines_a, V);
    chk("t1_line_len", line_len_a, H);
    chk("t1_err", err_a, 0);
    chk("t1_fv_f1", fv_cnt, 1);
    chk("pol0_locked", locked_b, 1);
    chk("pol0_lines", lines_b, V);
    chk("pol0_line_len", line_len_b, H);
    chk("pol0_err", err_b, 0);
    run_frame(V, -1, 0, 0, 0);
    chk("t1_locked_f2", locked_a, 1);
    chk("t1_fv_f2", fv_cnt, 2);
    run_frame(V, -1, 0, 1, 24'h000000);
    run_frame(V, -1, 0, 1, 24'hFF0000);
    chk("t2_pix_black", pix_a, VIS_W * VIS_H);
    chk("t2_sig_black", sig_a, 0);
    run_frame(V, -1, 0, 0, 0);
    chk("t2_pix_red", pix_a, VIS_W * VIS_H);
    chk("t2_sig_red", sig_a, sig_model(24'hFF0000, VIS_W * VIS_H));
    run_frame(V, -1, 0, 0, 0);
    chk("t2_pix_none", pix_a, 0);
    chk("t2_sig_none", sig_a, 0);
    run_frame(V, 3, 0, 0, 0);
    chk("t3_locked_pre", locked_a, 1);
    run_frame(V, -1, 0, 0, 0);
    chk("t3_locked_drop", locked_a, 0);
    chk("t3_err", err_a, 1);
    chk("t3_lines", lines_a, V);
    run_frame(V, -1, 0, 0, 0);
    chk("t3_relock", locked_a, 1);
    chk("t3_err_hold", err_a, 1);
    run_frame(V, -1, 0, 0, 0);
    run_frame(V, -1, 1, 0, 0);
    chk("t4_lines_coinc", lines_a, V);
    run_frame(V, -1, 1, 0, 0);
    chk("t4_lines_late", lines_a, V);
    chk("t4_locked_late", locked_a, 1);
    run_frame(V, -1, 0, 0, 0);
    chk("t4_lines_back", lines_a, V);
    chk("t4_err", err_a, 1);
    repeat (2100) step(0, 0, 0, 0);
    chk("t5_loss_locked", locked_a, 0);
    chk("t5_loss_err", err_a, 2);
    step(1, 0, 0, 0);
    chk("t5_line_len_sat", line_len_a, 2047);
    step(0, 0, 0, 0);
    run_frame(V, -1, 0, 0, 0);
    chk("t5_check_locked", locked_a, 0);
    run_frame(V, -1, 0, 0, 0);
    chk("t5_relock", locked_a, 1);
    chk("t5_err_hold", err_a, 2);
    run_frame(3, -1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_locked", locked_a, 0);
    chk("t5_arst_err", err_a, 0);
    chk("t5_arst_line_len", line_len_a, 0);
    chk("t5_arst_lines", lines_a, 0);
    chk("t5_arst_fv", fv_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(3, -1, 0, 0, 0);
    chk("t6_first_err", err_a, 0);
    repeat (254) run_frame(3, -1, 0, 0, 0);
    chk("t6_err_254", err_a, 254);
    chk("t6_lines_short", lines_a, 3);
    run_frame(3, -1, 0, 0, 0);
    chk("t6_err_255", err_a, 255);
    repeat (45) run_frame(3, -1, 0, 0, 0);
    chk("t6_err_sat", err_a, 255);
    chk("t6_locked", locked_a, 0);
    chk("pol0_err_sat", err_b, 255);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
